// File: rtl/maze_pkg.sv
// maze_pkg: constants and types shared by the command buffer.
//   CMD_W          width of a command word
//   CMD_BUF_DEPTH  default number of queue entries
//   ingress_state_e  ingress handshake states (IDLE, ACK)
package maze_pkg;

  localparam int unsigned CMD_W         = 16;
  localparam int unsigned CMD_BUF_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ingress_state_e;

endpackage

// File: rtl/cmd_buf_mem.sv
// cmd_buf_mem: DEPTH x WIDTH storage for the command queue.
// Synchronous write, asynchronous read, no reset on the data array.
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module cmd_buf_mem
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = CMD_BUF_DEPTH,
  parameter int unsigned WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cmd_buf.sv
// cmd_buf: command queue between the UART wrapper and cmd_proc.
// An ingress FSM (IDLE/ACK) captures in_cmd on the level flag in_cmd_rdy, acknowledges it
// with a one-cycle in_clr pulse and then ignores the still-high flag for one cycle.
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_cmd        command word from the wrapper
//   in_cmd_rdy    wrapper's pending-command level flag
//   in_clr        acknowledge pulse back to the wrapper
//   cmd           head-of-queue command (0 when empty)
//   cmd_rdy       queue non-empty
//   clr_cmd_rdy   pop strobe from cmd_proc
//   flush         synchronous discard of all entries
//   count, full   occupancy
//   ovfl          sticky drop indicator
// Build option: define CMD_BUF_DROP_EN to acknowledge and drop words arriving while full
// (setting ovfl) instead of holding them off; otherwise ovfl is tied to 0.
module cmd_buf
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = CMD_BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CMD_W-1:0]       in_cmd,
  input  logic                   in_cmd_rdy,
  output logic                   in_clr,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ovfl
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  ingress_state_e  state_q, state_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic            full_int;
  logic            can_accept;
  logic            take;
  logic            push;
  logic            pop;
  logic [CMD_W-1:0] mem_rdata;

  assign full_int   = (count_q == CntMax);
  // A full queue still accepts when the head is being popped in the same cycle.
  assign can_accept = !full_int || clr_cmd_rdy;

`ifdef CMD_BUF_DROP_EN
  // Every pending word in IDLE is acknowledged; words that don't fit are dropped.
  assign take = (state_q == IDLE) && in_cmd_rdy && !flush;
`else
  // While full and not popping the flag is left pending (backpressure).
  assign take = (state_q == IDLE) && in_cmd_rdy && !flush && can_accept;
`endif

  assign push = take && can_accept;
  assign pop  = clr_cmd_rdy && (count_q != '0) && !flush;

  // Gated by rst so the acknowledge is silent while reset is held.
  assign in_clr = take && !rst;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    case (state_q)
      IDLE:    if (take) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (flush) begin
      state_d = IDLE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef CMD_BUF_DROP_EN
  logic ovfl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfl_q <= 1'b0;
    end else if (flush) begin
      ovfl_q <= 1'b0;
    end else if (take && !can_accept) begin
      ovfl_q <= 1'b1;
    end
  end

  assign ovfl = ovfl_q;
`else
  assign ovfl = 1'b0;
`endif

  cmd_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (in_cmd),
    .raddr (head_q),
    .rdata (mem_rdata)
  );

  assign cmd_rdy = (count_q != '0);
  // Masked so cmd reads 0 when empty, including straight out of reset.
  assign cmd     = cmd_rdy ? mem_rdata : '0;
  assign full    = full_int;
  assign count   = count_q;

endmodule
